// File: rtl/serial_word_collector.sv
// serial_word_collector: reassembles n-bit words from a serial bit stream into a 2-entry valid/ready buffer.
// Defining SERIAL_COLLECTOR_PARITY_EN adds a trailing parity bit per frame and a per-word parity flag.
`timescale 1ns/1ps
module serial_word_collector #(
    parameter int n           = 4,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit EVEN_PARITY = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   SerialIn,
    input  logic                   SerialValid,
    output logic                   SerialReady,
    input  logic                   Flush,
    output logic [n-1:0]           OutData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic                   OutParityErr,
    output logic [$clog2(n+1)-1:0] BitCount,
    output logic                   DbgState
);
    localparam int CW = $clog2(n+1);

    // Handshake: a transfer happens on every rising edge where valid and ready are both high.
    // Ready is a function of registered state only, never of the partner's valid or ready.
    typedef enum logic {S_COLLECT = 1'b0, S_PARITY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  partial_q, partial_d, shifted, push_word;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, last_bit, push, pop, push_perr, parity_err;
    logic [n-1:0]  buf_data [2];
    logic          buf_perr [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count_q;

    assign SerialReady = (count_q != 2'd2);
    assign OutValid    = (count_q != 2'd0);
    assign accept      = SerialValid && SerialReady;
    assign pop         = OutValid && OutReady;
    assign last_bit    = (cnt_q == CW'(n - 1));
    assign parity_err  = (^{partial_q, SerialIn}) ^ ~EVEN_PARITY;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {partial_q[n-2:0], SerialIn};
        end else begin : g_lsb
            assign shifted = {SerialIn, partial_q[n-1:1]};
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_COLLECT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = S_COLLECT;
        end else if (accept) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
            if (state_q == S_COLLECT && last_bit) state_d = S_PARITY;
            else if (state_q == S_PARITY)         state_d = S_COLLECT;
`else
            state_d = S_COLLECT;
`endif
        end
    end

    // Flush outranks an accepted bit, including the completing one.
    always_comb begin
        partial_d = partial_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = shifted;
        push_perr = 1'b0;
        if (Flush) begin
            partial_d = '0;
            cnt_d     = '0;
        end else if (accept) begin
            case (state_q)
                S_COLLECT: begin
                    partial_d = shifted;
                    if (last_bit) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
                        cnt_d = CW'(n);
`else
                        push  = 1'b1;
                        cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    push      = 1'b1;
                    push_word = partial_q;
                    push_perr = parity_err;
                    cnt_d     = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            partial_q <= '0;
            cnt_q     <= '0;
        end else begin
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
        end
    end

    // Two-entry FIFO; a push never coincides with count==2 because SerialReady is low then.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_perr[i] <= 1'b0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= push_word;
                buf_perr[wr_ptr] <= push_perr;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign OutData      = buf_data[rd_ptr];
    assign OutParityErr = buf_perr[rd_ptr];
    assign BitCount     = cnt_q;
    assign DbgState     = state_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: an MSB-first and an LSB-first instance share one bit stream.
`timescale 1ns/1ps
module tb_serial_word_collector;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int W  = 2 * N + 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic SerialIn = 1'b0, SerialValid = 1'b0, Flush = 1'b0, OutReady = 1'b0;
  logic SerialReady, OutValid, OutParityErr, DbgState;
  logic [N-1:0] OutData;
  logic [CW-1:0] BitCount;
  logic lsb_ready, lsb_valid, lsb_perr, lsb_state;
  logic [N-1:0] lsb_data;
  logic [CW-1:0] lsb_count;

  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // clock/reset block
  always #5 Clock = ~Clock;

  serial_word_collector #(.n(N), .MSB_FIRST(1'b1), .EVEN_PARITY(1'b1)) u_dut (
    .Clock(Clock), .Reset(Reset), .SerialIn(SerialIn), .SerialValid(SerialValid),
    .SerialReady(SerialReady), .Flush(Flush), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .OutParityErr(OutParityErr), .BitCount(BitCount), .DbgState(DbgState)
  );

  serial_word_collector #(.n(N), .MSB_FIRST(1'b0), .EVEN_PARITY(1'b1)) u_lsb (
    .Clock(Clock), .Reset(Reset), .SerialIn(SerialIn), .SerialValid(SerialValid),
    .SerialReady(lsb_ready), .Flush(Flush), .OutData(lsb_data), .OutValid(lsb_valid),
    .OutReady(OutReady), .OutParityErr(lsb_perr), .BitCount(lsb_count), .DbgState(lsb_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks; each is entered and returns 1ns after a rising edge
  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    SerialValid = 1'b1;
    SerialIn = b;
    while (!SerialReady && guard < 100) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (!SerialReady) check("serial_ready_timeout", 32'(SerialReady), 32'd1);
    @(posedge Clock); #1;
    SerialValid = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic p);
    for (int i = N - 1; i >= 0; i--) send_bit(w[i]);
`ifdef SERIAL_COLLECTOR_PARITY_EN
    send_bit(p);
`endif
  endtask

  task automatic push_exp(input logic [N-1:0] w, input logic p);
    logic [N-1:0] rev;
    logic perr;
    for (int i = 0; i < N; i++) rev[i] = w[N-1-i];
`ifdef SERIAL_COLLECTOR_PARITY_EN
    perr = (^w) ^ p;
`else
    perr = 1'b0 & p;
`endif
    exp_q.push_back({perr, w, rev});
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic p);
    push_exp(w, p);
    send_frame(w, p);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge Clock); #1;
    end
  endtask

  // scoreboard: pop on each output handshake
  always @(negedge Clock) begin
    logic [W-1:0] e;
    if (Reset && OutValid && OutReady) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data_msb", 32'(OutData), 32'(e[2*N-1:N]));
        check("out_data_lsb", 32'(lsb_data), 32'(e[N-1:0]));
        check("out_perr", 32'(OutParityErr), 32'(e[2*N]));
        check("lsb_valid", 32'(lsb_valid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    idle(2);
    check("rst_serial_ready", 32'(SerialReady), 32'd1);
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_out_data", 32'(OutData), 32'd0);
    check("rst_out_perr", 32'(OutParityErr), 32'd0);
    check("rst_bit_count", 32'(BitCount), 32'd0);
    Reset = 1'b1;
    idle(1);

    // single word, streaming consumer; bit count and 1-cycle latency
    OutReady = 1'b1;
    push_exp(4'b1011, 1'b1);
    send_bit(1'b1); check("bc_1", 32'(BitCount), 32'd1);
    send_bit(1'b0); check("bc_2", 32'(BitCount), 32'd2);
    send_bit(1'b1); check("bc_3", 32'(BitCount), 32'd3);
    send_bit(1'b1);
`ifdef SERIAL_COLLECTOR_PARITY_EN
    check("bc_parity_phase", 32'(BitCount), 32'(N));
    check("no_valid_before_parity", 32'(OutValid), 32'd0);
    send_bit(1'b1);
`endif
    check("bc_wrap", 32'(BitCount), 32'd0);
    check("t1_valid", 32'(OutValid), 32'd1);
    check("t1_data_msb", 32'(OutData), 32'hb);
    check("t1_data_lsb", 32'(lsb_data), 32'hd);
    send_word(4'b1011, 1'b0);
    idle(2);
    check("t1_drained", 32'(OutValid), 32'd0);

    // backpressure: two words fill the buffer, the third is held off
    OutReady = 1'b0;
    send_word(4'b1010, 1'b0);
    send_word(4'b0110, 1'b0);
    check("full_ready_low", 32'(SerialReady), 32'd0);
    check("full_valid", 32'(OutValid), 32'd1);
    check("full_head", 32'(OutData), 32'ha);
    SerialValid = 1'b1;
    SerialIn = 1'b1;
    idle(3);
    check("held_bit_count", 32'(BitCount), 32'd0);
    check("held_ready_low", 32'(SerialReady), 32'd0);
    check("held_head_stable", 32'(OutData), 32'ha);
    push_exp(4'b1111, 1'b0);
    OutReady = 1'b1;
    send_frame(4'b1111, 1'b0);
    idle(3);
    check("t3_drained", 32'(OutValid), 32'd0);
    check("t3_ready", 32'(SerialReady), 32'd1);

    // flush with a bit in the same cycle, then a full word
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_flush_bc", 32'(BitCount), 32'd2);
    Flush = 1'b1; SerialValid = 1'b1; SerialIn = 1'b1;
    idle(1);
    Flush = 1'b0; SerialValid = 1'b0;
    check("flush_bc", 32'(BitCount), 32'd0);
    check("flush_no_push", 32'(OutValid), 32'd0);
    send_word(4'b0001, 1'b1);
    idle(2);

    // flush on the completing bit
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    Flush = 1'b1; SerialValid = 1'b1; SerialIn = 1'b1;
    idle(1);
    Flush = 1'b0; SerialValid = 1'b0;
    check("flush_last_bc", 32'(BitCount), 32'd0);
    check("flush_last_no_push", 32'(OutValid), 32'd0);
    idle(1);
    check("flush_last_still_empty", 32'(OutValid), 32'd0);

    // asynchronous reset mid-frame with one buffered word
    OutReady = 1'b0;
    send_frame(4'b1100, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("pre_rst_bc", 32'(BitCount), 32'd3);
    check("pre_rst_valid", 32'(OutValid), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(OutValid), 32'd0);
    check("async_rst_bc", 32'(BitCount), 32'd0);
    check("async_rst_ready", 32'(SerialReady), 32'd1);
    check("async_rst_data", 32'(OutData), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    OutReady = 1'b1;
    send_word(4'b0111, 1'b1);
    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
